// File: rtl/clock_pkg.sv
// Shared types and constants for the CORDIC request arbiter.
package clock_pkg;

  localparam int ANGLE_W     = 9;
  localparam int DATA_W      = 16;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 63;
  localparam int FULL_TURN   = 360;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_t;

  // Requester angles span 0..511; one subtraction brings them into 0..359.
  function automatic logic [ANGLE_W-1:0] reduce_angle(input logic [ANGLE_W-1:0] i_deg);
    return (i_deg >= ANGLE_W'(FULL_TURN)) ? i_deg - ANGLE_W'(FULL_TURN) : i_deg;
  endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester-side and CORDIC-side signals of the arbiter, bundled for port connection.
interface cordic_arbiter_if #(
  parameter int NUM_REQ = clock_pkg::DEF_NUM_REQ
);
  import clock_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [ANGLE_W*NUM_REQ-1:0] angle_in;
  logic [NUM_REQ-1:0]         ack;
  logic [DATA_W-1:0]          sin_out;
  logic [DATA_W-1:0]          cos_out;
  logic                       err_timeout;

  logic                       cordic_start;
  logic [DATA_W-1:0]          cordic_angle;
  logic [DATA_W-1:0]          cordic_sin;
  logic [DATA_W-1:0]          cordic_cos;
  logic                       cordic_done;

  modport slave (
    input  req, angle_in, cordic_sin, cordic_cos, cordic_done,
    output ack, sin_out, cos_out, err_timeout, cordic_start, cordic_angle
  );

  modport master (
    output req, angle_in, cordic_sin, cordic_cos, cordic_done,
    input  ack, sin_out, cos_out, err_timeout, cordic_start, cordic_angle
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin pick: first asserted request at or above the pointer, wrapping around.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_valid
);

  logic [IDX_W:0] w_pos;

  // Walk from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = {1'b0, i_rr_ptr} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      end
      if (i_req[w_pos[IDX_W-1:0]]) begin
        o_grant = w_pos[IDX_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one external cordic_sin_cos among NUM_REQ requesters, one operation at a time.
//   state   | meaning
//   S_IDLE  | waiting for any request; grant, latch index and reduced angle
//   S_ISSUE | one-cycle cordic_start, timeout counter cleared
//   S_WAIT  | waiting for cordic_done or timeout expiry
//   S_RESP  | ack to granted requester, advance round-robin pointer
module cordic_arbiter #(
  parameter int NUM_REQ = clock_pkg::DEF_NUM_REQ,
  parameter int TIMEOUT = clock_pkg::DEF_TIMEOUT
) (
  input logic             clk,
  input logic             reset_n,
  cordic_arbiter_if.slave bus
);
  import clock_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_grant;
  logic               w_any;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [DATA_W-1:0]  r_angle;
  logic [DATA_W-1:0]  r_sin;
  logic [DATA_W-1:0]  r_cos;
  logic               w_expire;
  logic [ANGLE_W-1:0] w_req_angle;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_valid  (w_any)
  );

  assign w_req_angle = bus.angle_in[int'(w_grant)*ANGLE_W +: ANGLE_W];
  // Counter reaches TIMEOUT on the same edge that leaves WAIT.
  assign w_expire    = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.cordic_done || w_expire) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_angle  <= '0;
      r_sin    <= '0;
      r_cos    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_grant;
            r_angle <= DATA_W'(reduce_angle(w_req_angle));
            r_err   <= 1'b0;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (bus.cordic_done) begin
            r_sin <= bus.cordic_sin;
            r_cos <= bus.cordic_cos;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_expire) begin
              r_sin <= '0;
              r_cos <= '0;
              r_err <= 1'b1;
            end
          end
        end
        S_RESP: r_rr_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ack          = (r_state == S_RESP) ? (NUM_REQ'(1) << r_idx) : '0;
  assign bus.err_timeout  = (r_state == S_RESP) && r_err;
  assign bus.cordic_start = (r_state == S_ISSUE);
  assign bus.cordic_angle = r_angle;
  assign bus.sin_out      = r_sin;
  assign bus.cos_out      = r_cos;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: transaction-level timeline model plus directed literal checks.
module tb_cordic_arbiter;

  localparam int NREQ     = 4;
  localparam int TMO      = 63;
  localparam int NJOB     = 256;
  localparam int RAND_OPS = 150;

  logic clk = 1'b0;
  logic reset_n;

  cordic_arbiter_if #(.NUM_REQ(NREQ)) bus();

  cordic_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Per-operation CORDIC behaviour: latency after start (0 = never answers), results, spurious done in ISSUE.
  int          job_lat  [NJOB];
  logic [15:0] job_sin  [NJOB];
  logic [15:0] job_cos  [NJOB];
  bit          job_spur [NJOB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_angle(input int r, input int deg);
    bus.angle_in[r*9 +: 9] = 9'(deg);
  endtask

  // CORDIC stand-in: answers each start according to the next job entry.
  int drv_job  = 0;
  int drv_pend = 0;
  int drv_cur  = 0;
  always @(posedge clk) begin
    #1;
    bus.cordic_done = 1'b0;
    bus.cordic_sin  = 16'($urandom);
    bus.cordic_cos  = 16'($urandom);
    if (reset_n !== 1'b1) begin
      drv_pend = 0;
    end else begin
      if (drv_pend > 0) begin
        drv_pend--;
        if (drv_pend == 0) begin
          bus.cordic_done = 1'b1;
          bus.cordic_sin  = job_sin[drv_cur];
          bus.cordic_cos  = job_cos[drv_cur];
        end
      end
      if (bus.cordic_start === 1'b1) begin
        if (drv_job < NJOB) begin
          drv_cur  = drv_job;
          drv_pend = job_lat[drv_job];
          if (job_spur[drv_job]) bus.cordic_done = 1'b1;
        end
        drv_job++;
      end
    end
  end

  // Timeline model: a grant at cycle g starts at g+1 and acks at g+1+L+1, or g+TMO+2 on timeout.
  bit          m_busy = 1'b0;
  int          m_g, m_A, m_idx, m_ptr = 0, m_job = 0;
  bit          m_err;
  int          m_ang;
  logic [15:0] m_rsin, m_rcos;
  logic [15:0] m_sin = '0, m_cos = '0;
  logic [NREQ-1:0] e_ack;
  bit          e_err, e_start, m_found;
  int          m_r, m_lat, m_deg;

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_err_timeout", 32'(bus.err_timeout), 0);
      check("rst_cordic_start", 32'(bus.cordic_start), 0);
      check("rst_cordic_angle", 32'(bus.cordic_angle), 0);
      check("rst_sin_out", 32'(bus.sin_out), 0);
      check("rst_cos_out", 32'(bus.cos_out), 0);
      m_busy = 1'b0;
      m_ptr  = 0;
      m_sin  = '0;
      m_cos  = '0;
    end else begin
      e_ack   = '0;
      e_err   = 1'b0;
      e_start = m_busy && (cyc == m_g + 1);
      if (m_busy && cyc == m_A) begin
        e_ack[m_idx] = 1'b1;
        e_err = m_err;
        m_sin = m_err ? 16'h0 : m_rsin;
        m_cos = m_err ? 16'h0 : m_rcos;
      end
      check("ack", 32'(bus.ack), 32'(e_ack));
      check("err_timeout", 32'(bus.err_timeout), 32'(e_err));
      check("cordic_start", 32'(bus.cordic_start), 32'(e_start));
      check("sin_out", 32'(bus.sin_out), 32'(m_sin));
      check("cos_out", 32'(bus.cos_out), 32'(m_cos));
      if (m_busy && cyc > m_g && cyc < m_A)
        check("cordic_angle", 32'(bus.cordic_angle), 32'(m_ang));

      if (m_busy && cyc == m_A) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % NREQ;
      end else if (!m_busy) begin
        m_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          m_r = (m_ptr + k) % NREQ;
          if (!m_found && bus.req[m_r]) begin
            m_found = 1'b1;
            m_idx   = m_r;
          end
        end
        if (m_found) begin
          m_busy = 1'b1;
          m_g    = cyc;
          m_deg  = int'(bus.angle_in[m_idx*9 +: 9]);
          m_ang  = (m_deg >= 360) ? m_deg - 360 : m_deg;
          m_lat  = (m_job < NJOB) ? job_lat[m_job] : 0;
          m_rsin = (m_job < NJOB) ? job_sin[m_job] : 16'h0;
          m_rcos = (m_job < NJOB) ? job_cos[m_job] : 16'h0;
          m_job++;
          if (m_lat >= 1 && m_lat <= TMO) begin
            m_A   = m_g + m_lat + 2;
            m_err = 1'b0;
          end else begin
            m_A   = m_g + TMO + 2;
            m_err = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_ack(input int limit, output int at, output logic [NREQ-1:0] a);
    at = -1;
    a  = '0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.ack != '0) begin
        at = cyc;
        a  = bus.ack;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: no ack within %0d cycles (cycle %0d)", limit, cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  int              g, at, idx, acks_seen;
  logic [NREQ-1:0] a;
  int              ord     [5];
  int              exp_ord [5] = '{0, 1, 2, 3, 0};
  bit              pend    [NREQ];

  initial begin
    for (int j = 0; j < NJOB; j++) begin
      job_sin[j]  = 16'($urandom);
      job_cos[j]  = 16'($urandom);
      job_spur[j] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0)      job_lat[j] = 0;
      else if ($urandom_range(0, 3) == 0) job_lat[j] = $urandom_range(40, 63);
      else                                job_lat[j] = $urandom_range(1, 12);
    end
    job_lat[0] = 16; job_sin[0] = 16'h1234; job_cos[0] = 16'h5678; job_spur[0] = 0;
    job_lat[1] = 5;  job_spur[1] = 0;
    job_lat[2] = 0;  job_spur[2] = 0;
    job_lat[3] = 7;  job_sin[3] = 16'hAAAA; job_cos[3] = 16'h5555; job_spur[3] = 1;
    for (int j = 4; j <= 8; j++) job_lat[j] = $urandom_range(1, 20);
    job_lat[9]  = 40;
    job_lat[10] = 3;

    reset_n         = 1'b0;
    bus.req         = '0;
    bus.angle_in    = '0;
    bus.cordic_done = 1'b0;
    bus.cordic_sin  = '0;
    bus.cordic_cos  = '0;
    repeat (3) tick();
    check("reset_ack", 32'(bus.ack), 0);
    check("reset_sin_out", 32'(bus.sin_out), 0);
    reset_n = 1'b1;
    tick();

    // single request, angle held stable against later changes
    g = cyc; bus.req = 4'b0001; set_angle(0, 90);
    tick();
    check("single_start", 32'(bus.cordic_start), 1);
    check("single_angle", 32'(bus.cordic_angle), 90);
    set_angle(0, 300);
    wait_ack(100, at, a);
    check("single_ack", 32'(a), 32'h1);
    check("single_latency", 32'(at - g), 18);
    check("single_sin", 32'(bus.sin_out), 32'h1234);
    check("single_cos", 32'(bus.cos_out), 32'h5678);
    check("single_err", 32'(bus.err_timeout), 0);
    bus.req = '0;
    tick();

    // wrap 400 -> 40, requester drops req right after grant
    g = cyc; bus.req = 4'b0100; set_angle(2, 400);
    tick();
    check("wrap_angle", 32'(bus.cordic_angle), 40);
    bus.req[2] = 1'b0;
    wait_ack(100, at, a);
    check("wrap_ack", 32'(a), 32'h4);
    check("wrap_latency", 32'(at - g), 7);
    tick();

    // CORDIC never answers
    g = cyc; bus.req = 4'b0010; set_angle(1, 200);
    wait_ack(150, at, a);
    check("tmo_ack", 32'(a), 32'h2);
    check("tmo_latency", 32'(at - g), 65);
    check("tmo_err", 32'(bus.err_timeout), 1);
    check("tmo_sin", 32'(bus.sin_out), 0);
    check("tmo_cos", 32'(bus.cos_out), 0);
    bus.req = '0;
    tick();

    // spurious done during ISSUE is ignored
    g = cyc; bus.req = 4'b1000; set_angle(3, 359);
    wait_ack(100, at, a);
    check("spur_ack", 32'(a), 32'h8);
    check("spur_latency", 32'(at - g), 9);
    check("spur_sin", 32'(bus.sin_out), 32'hAAAA);
    check("spur_cos", 32'(bus.cos_out), 32'h5555);
    bus.req = '0;
    tick();

    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // contention from pointer 0
    bus.req = 4'b1111;
    for (int r = 0; r < NREQ; r++) set_angle(r, $urandom_range(0, 511));
    for (int k = 0; k < 5; k++) begin
      wait_ack(100, at, a);
      idx = -1;
      if ($countones(a) == 1)
        for (int i = 0; i < NREQ; i++) if (a[i]) idx = i;
      ord[k] = idx;
    end
    bus.req = '0;
    for (int k = 0; k < 5; k++) check($sformatf("rr_order_%0d", k), 32'(ord[k]), 32'(exp_ord[k]));
    tick();

    // reset in WAIT abandons the op; pointer restarts at 0
    bus.req = 4'b0100; set_angle(2, 123);
    repeat (10) tick();
    reset_n = 1'b0; bus.req = '0;
    repeat (2) tick();
    check("rstwait_ack", 32'(bus.ack), 0);
    check("rstwait_start", 32'(bus.cordic_start), 0);
    check("rstwait_angle", 32'(bus.cordic_angle), 0);
    check("rstwait_sin", 32'(bus.sin_out), 0);
    reset_n = 1'b1;
    tick();
    g = cyc; bus.req = 4'b1001; set_angle(0, 45); set_angle(3, 46);
    wait_ack(50, at, a);
    check("post_rst_ack", 32'(a), 32'h1);
    check("post_rst_latency", 32'(at - g), 5);
    bus.req = '0;
    tick();

    // randomized traffic
    acks_seen = 0;
    for (int r = 0; r < NREQ; r++) pend[r] = 1'b0;
    for (int c = 0; c < 25000 && acks_seen < RAND_OPS; c++) begin
      tick();
      for (int r = 0; r < NREQ; r++) begin
        if (pend[r]) begin
          if (bus.ack[r]) begin
            pend[r]    = 1'b0;
            bus.req[r] = 1'b0;
            acks_seen++;
          end else begin
            if ($urandom_range(0, 15) == 0) set_angle(r, $urandom_range(0, 511));
            if (bus.req[r] && m_busy && m_idx == r && cyc > m_g + 1 && $urandom_range(0, 31) == 0)
              bus.req[r] = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          bus.req[r] = 1'b1;
          set_angle(r, $urandom_range(0, 511));
          pend[r] = 1'b1;
        end
      end
    end
    check("rand_ops_done", 32'(acks_seen >= RAND_OPS), 1);
    bus.req = '0;
    repeat (80) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4; number of requesters sharing one cordic_sin_cos instance.
REQ-002 SHALL have parameter TIMEOUT, default 63; maximum cycles waited for cordic_done.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous and active-low.
REQ-005 req  input  NUM_REQ  per-requester request level; held high until that requester's ack.
REQ-006 angle_in  input  9*NUM_REQ  per-requester angle in degrees; requester r occupies bits [9r+8:9r].
REQ-007 ack  output  NUM_REQ  one-cycle result-valid pulse for the granted requester.
REQ-008 sin_out, cos_out  output  16 each  result; valid while ack is high, held until the next ack.
REQ-009 err_timeout  output  1  one-cycle pulse, coincident with ack, when the CORDIC did not answer.
REQ-010 cordic_start  output  1  one-cycle start pulse to cordic_sin_cos.
REQ-011 cordic_angle  output  16  angle to cordic_sin_cos; stable from ISSUE through WAIT.
REQ-012 cordic_sin, cordic_cos  input  16 each  CORDIC results, same encoding as sin_out/cos_out.
REQ-013 cordic_done  input  1  CORDIC completion; sampled only in WAIT.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-015 IDLE: if any req bit is high, grant one requester by round-robin starting at rr_ptr, latch its index and angle, go to ISSUE; else stay in IDLE.
REQ-016 Round-robin: search req from rr_ptr upward with wrap-around; in RESP, rr_ptr SHALL become granted index+1 mod NUM_REQ.
REQ-017 Angle reduction: latched angle >= 360 SHALL be reduced by 360 once; cordic_angle = reduced angle zero-extended to 16 bits.
REQ-018 ISSUE: assert cordic_start for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-019 WAIT: on cordic_done, capture cordic_sin and cordic_cos and go to RESP; otherwise increment the timeout counter.
REQ-020 If the timeout counter reaches TIMEOUT in WAIT without cordic_done, capture sin = 0 and cos = 0, set the error flag, and go to RESP.
REQ-021 cordic_done high in IDLE, ISSUE or RESP SHALL be ignored.
REQ-022 RESP: drive ack[granted] = 1, drive err_timeout = error flag, update rr_ptr, go to IDLE; at most one ack bit is ever high.
REQ-023 Latency: req sampled in IDLE at cycle 0 gives cordic_start at cycle 1; cordic_done at cycle N gives ack at cycle N+1.
REQ-024 req and angle_in changes after the grant cycle SHALL NOT affect the in-flight operation.
REQ-025 req deasserting before ack SHALL NOT abort the operation; the ack is still issued.
REQ-026 Minimum spacing between two acks SHALL be 4 cycles.

Reset
REQ-027 While reset_n is low: state = IDLE, rr_ptr = 0, timeout counter = 0, ack = 0, err_timeout = 0, cordic_start = 0, cordic_angle = 0, sin_out = 0, cos_out = 0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation without issuing an ack; after release the block SHALL restart from IDLE.

Structure
REQ-029 Shared package clock_pkg SHALL hold: the FSM state enum, ANGLE_W = 9, DATA_W = 16, and the default NUM_REQ and TIMEOUT values.
REQ-030 Round-robin selection SHALL be a sub-module rr_picker (inputs req and rr_ptr; outputs grant index and any-valid).
REQ-031 The CORDIC instance SHALL live outside this block.

Verification
REQ-032 Single request: req = 0001, angle 90, CORDIC model done 16 cycles after start -> cordic_angle = 90, ack = 0001 at cycle 18, model results on sin_out/cos_out.
REQ-033 Contention: req = 1111 held, rr_ptr = 0 -> grant order 0, 1, 2, 3, 0; no requester starves.
REQ-034 Wrap: angle_in = 400 -> cordic_angle = 40.
REQ-035 Timeout: model never asserts done, TIMEOUT = 63 -> ack plus err_timeout at 64 cycles after start, sin_out = 0, cos_out = 0.
REQ-036 Reset in WAIT: reset_n low for 2 cycles -> no ack, all outputs 0, next request served normally starting with requester 0 priority.
REQ-037 Spurious done: cordic_done high during ISSUE -> ignored; result captured only on the later done in WAIT.
